// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: per-slot digit select, BCD decode,
// leading-zero blanking, PWM dimming, guard band and frame-synchronous buffer swap.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD        = 2,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    update_i,
  input  logic                    blank_lz_i,
  input  logic [3:0]              brightness_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   dig_sel_o,
  output logic                    frame_done_o
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]      GUARD_C  = DIV_W'(GUARD);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_INV  = {7{COMMON_ANODE}};
  localparam logic [NUM_DIGITS-1:0] SEL_INV  = {NUM_DIGITS{COMMON_ANODE}};

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [3:0]              pwm_cnt;
  logic [4*NUM_DIGITS-1:0] shadow_dig;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] active_dig;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic                    pending;
  logic                    frame_end;

  logic [3:0]              digit_p0;
  logic                    dp_sel_p0;
  logic                    blanked_p0;
  logic                    zero_above;
  logic                    lit_p0;
  logic [NUM_DIGITS-1:0]   sel_p0;

  logic [6:0]              seg_p1;
  logic                    dp_p1;
  logic [NUM_DIGITS-1:0]   sel_p1;
  logic                    frame_done_p1;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h40;
    endcase
    return seg;
  endfunction

  assign frame_end = (div_cnt == DIV_LAST) && (digit_idx == IDX_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt   <= '0;
      digit_idx <= '0;
      pwm_cnt   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (div_cnt == DIV_LAST) begin
        div_cnt   <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // An update landing on the boundary edge bypasses the shadow and is shown next frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_dig <= '0;
      shadow_dp  <= '0;
      active_dig <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
    end else if (frame_end && update_i) begin
      shadow_dig <= digits_i;
      shadow_dp  <= dp_i;
      active_dig <= digits_i;
      active_dp  <= dp_i;
      pending    <= 1'b0;
    end else if (frame_end && pending) begin
      active_dig <= shadow_dig;
      active_dp  <= shadow_dp;
      pending    <= 1'b0;
    end else if (update_i) begin
      shadow_dig <= digits_i;
      shadow_dp  <= dp_i;
      pending    <= 1'b1;
    end
  end

  // Stage p0: select active digit and evaluate blanking from the top digit downwards.
  always_comb begin
    digit_p0   = 4'd0;
    dp_sel_p0  = 1'b0;
    blanked_p0 = 1'b0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (active_dig[4*k +: 4] == 4'd0);
      if (digit_idx == IDX_W'(k)) begin
        digit_p0   = active_dig[4*k +: 4];
        dp_sel_p0  = active_dp[k];
        blanked_p0 = blank_lz_i && zero_above && (k != 0);
      end
    end
  end

  assign lit_p0 = (div_cnt >= GUARD_C) && (pwm_cnt < brightness_i) && !blanked_p0;
  assign sel_p0 = lit_p0 ? (NUM_DIGITS'(1) << digit_idx) : '0;

  // Stage p1: output registers, pin polarity applied here only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_p1        <= SEG_INV;
      dp_p1         <= COMMON_ANODE;
      sel_p1        <= SEL_INV;
      frame_done_p1 <= 1'b0;
    end else begin
      seg_p1        <= (lit_p0 ? seg_decode(digit_p0) : 7'd0) ^ SEG_INV;
      dp_p1         <= (lit_p0 && dp_sel_p0) ^ COMMON_ANODE;
      sel_p1        <= sel_p0 ^ SEL_INV;
      frame_done_p1 <= frame_end;
    end
  end

  assign seg_o        = seg_p1;
  assign dp_o         = dp_p1;
  assign dig_sel_o    = sel_p1;
  assign frame_done_o = frame_done_p1;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: vector table, directed corner sequences and
// randomized traffic checked against a cycle-count based reference model.
module tb_sevenseg_scan_driver;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int GD = 2;
  localparam int FR = SD * ND;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic        update = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bright = 4'd15;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fd_a, fd_b;
  logic [3:0] sel_a, sel_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sevenseg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD), .COMMON_ANODE(1'b0)) dut_cc (
    .clk_i(clk), .rst_ni(rst_n), .digits_i(digits), .dp_i(dp), .update_i(update),
    .blank_lz_i(blank_lz), .brightness_i(bright), .seg_o(seg_a), .dp_o(dp_a),
    .dig_sel_o(sel_a), .frame_done_o(fd_a));

  sevenseg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD), .COMMON_ANODE(1'b1)) dut_ca (
    .clk_i(clk), .rst_ni(rst_n), .digits_i(digits), .dp_i(dp), .update_i(update),
    .blank_lz_i(blank_lz), .brightness_i(bright), .seg_o(seg_b), .dp_o(dp_b),
    .dig_sel_o(sel_b), .frame_done_o(fd_b));

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Reference model: everything derives from n, the number of cycles since reset.
  int          n;
  logic [15:0] m_act, m_sh;
  logic [3:0]  m_adp, m_sdp;
  logic        m_pend;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;
  logic [3:0]  e_sel;

  function automatic int f_idx(input int c);
    return (c / SD) % ND;
  endfunction

  function automatic logic [3:0] f_digit(input logic [15:0] act, input int idx);
    return 4'(act >> (4 * idx));
  endfunction

  function automatic logic [3:0] f_sel(input int c, input logic [15:0] act,
                                       input logic blz, input logic [3:0] br);
    int idx;
    logic [15:0] upper;
    idx = f_idx(c);
    upper = act >> (4 * idx);
    if ((c % SD) < GD || (c % 16) >= int'(br)) return 4'd0;
    if (blz && idx != 0 && upper == 16'd0) return 4'd0;
    return 4'(1 << idx);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 0; m_act <= '0; m_sh <= '0; m_adp <= '0; m_sdp <= '0; m_pend <= 1'b0;
      e_seg <= '0; e_dp <= 1'b0; e_sel <= '0; e_fd <= 1'b0;
    end else begin
      n     <= n + 1;
      e_sel <= f_sel(n, m_act, blank_lz, bright);
      e_seg <= (f_sel(n, m_act, blank_lz, bright) != 4'd0) ? seg_tab[f_digit(m_act, f_idx(n))] : 7'd0;
      e_dp  <= (f_sel(n, m_act, blank_lz, bright) != 4'd0) && m_adp[f_idx(n)];
      e_fd  <= (n % FR) == FR - 1;
      if ((n % FR) == FR - 1 && update) begin
        m_act <= digits; m_adp <= dp; m_pend <= 1'b0;
      end else if ((n % FR) == FR - 1 && m_pend) begin
        m_act <= m_sh; m_adp <= m_sdp; m_pend <= 1'b0;
      end else if (update) begin
        m_sh <= digits; m_sdp <= dp; m_pend <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (seg_a !== e_seg || dp_a !== e_dp || sel_a !== e_sel || fd_a !== e_fd) begin
      failures++;
      if (failures <= 20)
        $display("FAIL scoreboard t=%0t got seg=%h dp=%b sel=%b fd=%b want seg=%h dp=%b sel=%b fd=%b",
                 $time, seg_a, dp_a, sel_a, fd_a, e_seg, e_dp, e_sel, e_fd);
    end
    checks++;
    if (seg_b !== ~seg_a || dp_b !== ~dp_a || sel_b !== ~sel_a || fd_b !== fd_a) begin
      failures++;
      if (failures <= 20)
        $display("FAIL polarity t=%0t got ca seg=%h dp=%b sel=%b fd=%b cc seg=%h dp=%b sel=%b fd=%b",
                 $time, seg_b, dp_b, sel_b, fd_b, seg_a, dp_a, sel_a, fd_a);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic do_update(input logic [15:0] d, input logic [3:0] p);
    digits = d; dp = p; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  // Outputs seen at a falling edge come from model cycle n-1.
  task automatic wait_vis(input int pos);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FR && !found; i++) begin
      @(negedge clk);
      if (((n - 1) % FR) == pos) found = 1'b1;
    end
    if (!found) begin
      failures++;
      $display("FAIL wait_vis timeout pos=%0d", pos);
    end
  endtask

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        blz;
    int          slot;
    logic [6:0]  seg;
    logic        dpo;
    logic [3:0]  sel;
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV];

  initial begin
    int cnt;
    tv[0]  = '{16'h1234, 4'b0000, 1'b0, 0, 7'h66, 1'b0, 4'b0001};
    tv[1]  = '{16'h1234, 4'b0000, 1'b0, 1, 7'h4F, 1'b0, 4'b0010};
    tv[2]  = '{16'h1234, 4'b0000, 1'b0, 2, 7'h5B, 1'b0, 4'b0100};
    tv[3]  = '{16'h1234, 4'b0000, 1'b0, 3, 7'h06, 1'b0, 4'b1000};
    tv[4]  = '{16'h0007, 4'b0000, 1'b1, 0, 7'h07, 1'b0, 4'b0001};
    tv[5]  = '{16'h0007, 4'b0000, 1'b1, 1, 7'h00, 1'b0, 4'b0000};
    tv[6]  = '{16'h0007, 4'b0000, 1'b1, 3, 7'h00, 1'b0, 4'b0000};
    tv[7]  = '{16'h0000, 4'b0000, 1'b1, 0, 7'h3F, 1'b0, 4'b0001};
    tv[8]  = '{16'h0000, 4'b0000, 1'b1, 2, 7'h00, 1'b0, 4'b0000};
    tv[9]  = '{16'h0007, 4'b0000, 1'b0, 3, 7'h3F, 1'b0, 4'b1000};
    tv[10] = '{16'h00B0, 4'b0010, 1'b0, 1, 7'h40, 1'b1, 4'b0010};
    tv[11] = '{16'h00B0, 4'b0010, 1'b0, 0, 7'h3F, 1'b0, 4'b0001};
    tv[12] = '{16'h00B0, 4'b0010, 1'b0, 2, 7'h3F, 1'b0, 4'b0100};
    tv[13] = '{16'h0507, 4'b0000, 1'b1, 1, 7'h3F, 1'b0, 4'b0010};
    tv[14] = '{16'h0007, 4'b1000, 1'b1, 3, 7'h00, 1'b0, 4'b0000};

    repeat (3) @(negedge clk);
    chk("reset_seg_cc", 32'(seg_a), 32'h00);
    chk("reset_sel_cc", 32'(sel_a), 32'h0);
    chk("reset_dp_fd_cc", 32'({dp_a, fd_a}), 32'h0);
    chk("reset_seg_ca", 32'(seg_b), 32'h7F);
    chk("reset_sel_ca", 32'(sel_b), 32'hF);
    chk("reset_dp_ca", 32'(dp_b), 32'h1);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      blank_lz = tv[i].blz;
      do_update(tv[i].digits, tv[i].dp);
      repeat (70) @(negedge clk);
      wait_vis(tv[i].slot * SD + 4);
      chk($sformatf("vec%0d_seg", i), 32'(seg_a), 32'(tv[i].seg));
      chk($sformatf("vec%0d_dp", i), 32'(dp_a), 32'(tv[i].dpo));
      chk($sformatf("vec%0d_sel", i), 32'(sel_a), 32'(tv[i].sel));
    end

    // Asynchronous reset in the middle of slot 2.
    blank_lz = 1'b0;
    do_update(16'h1234, 4'b0100);
    repeat (70) @(negedge clk);
    wait_vis(2 * SD + 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg_cc", 32'(seg_a), 32'h00);
    chk("async_rst_sel_cc", 32'(sel_a), 32'h0);
    chk("async_rst_dp_cc", 32'(dp_a), 32'h0);
    chk("async_rst_sel_ca", 32'(sel_b), 32'hF);
    chk("async_rst_seg_ca", 32'(seg_b), 32'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_guard_sel", 32'(sel_a), 32'h0);
    repeat (3) @(negedge clk);
    chk("post_rst_slot0_sel", 32'(sel_a), 32'h1);
    chk("post_rst_slot0_seg", 32'(seg_a), 32'h3F);

    cnt = 0;
    repeat (10 * FR) begin
      @(negedge clk);
      if (fd_a) cnt++;
    end
    chk("frame_done_count", 32'(cnt), 32'd10);

    // Mid-frame update must not tear the frame in progress.
    do_update(16'h1234, 4'b0000);
    repeat (70) @(negedge clk);
    wait_vis(SD + 4);
    do_update(16'h8888, 4'b0000);
    wait_vis(3 * SD + 4);
    chk("tear_old_slot3_seg", 32'(seg_a), 32'h06);
    wait_vis(4);
    chk("tear_new_slot0_seg", 32'(seg_a), 32'h7F);

    // Update on the boundary cycle itself.
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 2 * FR && !hit; i++) begin
        @(negedge clk);
        if ((n % FR) == FR - 1) hit = 1'b1;
      end
      if (!hit) begin
        failures++;
        $display("FAIL boundary_align timeout");
      end
    end
    do_update(16'h5555, 4'b0000);
    wait_vis(4);
    chk("boundary_slot0_seg", 32'(seg_a), 32'h6D);
    wait_vis(3 * SD + 4);
    chk("boundary_slot3_seg", 32'(seg_a), 32'h6D);

    // Brightness 0 and 8.
    do_update(16'h1234, 4'b0000);
    bright = 4'd0;
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (2 * FR) begin
      if (sel_a != 4'd0) cnt++;
      @(negedge clk);
    end
    chk("bright0_lit", 32'(cnt), 32'd0);
    bright = 4'd8;
    @(negedge clk);
    cnt = 0;
    repeat (2 * FR) begin
      if (sel_a != 4'd0) cnt++;
      @(negedge clk);
    end
    chk("bright8_lit", 32'(cnt), 32'd24);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] rd;
      for (int k = 0; k < 4; k++)
        rd[4*k +: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16);
      digits = rd;
      dp = 4'($urandom);
      update = ($urandom % 6 == 0);
      if ($urandom % 40 == 0) blank_lz = ~blank_lz;
      if ($urandom % 50 == 0) bright = 4'($urandom);
      @(negedge clk);
    end
    update = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Consumes packed BCD digits from the clock's counter chain and drives a time-multiplexed 7-segment display: one digit lit per scan slot, segment decode, leading-zero blanking, PWM brightness and an anti-ghosting guard.
- Sits between the hours/minutes/seconds counters and the physical segment/digit pins.
- Digit updates are double-buffered and take effect only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 1000, clock cycles per digit slot (min 8).
- GUARD, 2, cycles at the start of each slot with all digits off (must be < SCAN_DIV).
- COMMON_ANODE, 0, 1 inverts seg_o, dp_o and dig_sel_o (active-low pins).

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- digits_i  input  4*NUM_DIGITS  packed BCD; digit k = bits [4k+3:4k]; digit 0 = least significant, rightmost.
- dp_i  input  NUM_DIGITS  decimal point per digit.
- update_i  input  1  strobe: capture digits_i/dp_i into the shadow buffer.
- blank_lz_i  input  1  enable leading-zero blanking.
- brightness_i  input  4  duty level 0 (off) .. 15.
- seg_o  output  7  segments {g,f,e,d,c,b,a}, registered.
- dp_o  output  1  decimal point of the active digit, registered.
- dig_sel_o  output  NUM_DIGITS  one-hot digit enable (or all inactive), registered.
- frame_done_o  output  1  one-cycle pulse after the last slot of each frame.

Behaviour:
- Reset (async assert, sync deassert on clk_i edge):
  - div_cnt = 0, digit_idx = 0, pwm_cnt = 0.
  - Shadow, active and pending = 0.
  - All outputs inactive at pin polarity: seg_o/dp_o/dig_sel_o = 0 when COMMON_ANODE = 0, all-ones when 1; frame_done_o = 0.
- Prescaler:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - At div_cnt == SCAN_DIV-1, digit_idx advances 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0.
- Frame boundary: the cycle where div_cnt == SCAN_DIV-1 and digit_idx == NUM_DIGITS-1. At that edge:
  - frame_done_o is asserted for exactly the next cycle.
  - If pending = 1, shadow copies to active and pending clears.
- update_i:
  - Captures digits_i/dp_i into shadow and sets pending.
  - A later update_i in the same frame overwrites shadow (last writer wins).
  - update_i in the frame-boundary cycle itself: the captured values go directly to active at that edge; pending stays 0.
- PWM:
  - 4-bit pwm_cnt increments every cycle, wrapping 15 -> 0.
  - on = (pwm_cnt < brightness_i). brightness 0 means never lit; 15 means 15/16 duty.
- Digit enable: dig_sel bit digit_idx active iff div_cnt >= GUARD and on and not blanked; otherwise all digits inactive.
- Leading-zero blanking, when blank_lz_i = 1:
  - Active digit k is blanked iff every digit from NUM_DIGITS-1 down to k is 0 and k != 0.
  - Digit 0 is never blanked.
  - dp of a blanked digit is also suppressed.
- Segment decode (active-high before polarity):
  - 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66, 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F.
  - Codes 10..15 display a dash, 0x40.
  - seg_o/dp_o are forced 0 (inactive) whenever dig_sel is all-inactive.
- Latency: outputs are registered, one cycle after the div_cnt/digit_idx/pwm_cnt state that produced them.
- Polarity: COMMON_ANODE = 1 applies a bitwise inversion to seg_o, dp_o and dig_sel_o at the output registers only.

Test Plan:
- Reset mid-slot:
  - Stimulus: SCAN_DIV=8, GUARD=2, NUM_DIGITS=4, brightness 15; assert rst_ni low during slot 2.
  - Response: outputs go inactive immediately, without waiting for a clock edge; after release, scan restarts at digit 0 with div_cnt = 0.
- Basic scan:
  - Stimulus: update_i with digits 1,2,3,4 (digit3..digit0); wait one frame.
  - Response in steady state: dig_sel_o = 0001 with seg_o = 0x66, then 0010/0x4F, 0100/0x5B, 1000/0x06; each slot shows 2 dark guard cycles then 6 lit cycles (minus PWM-off cycles where pwm_cnt = 15); frame_done_o pulses once every 32 cycles.
- Leading-zero blanking:
  - Stimulus: digits 0,0,0,7 with blank_lz_i = 1.
  - Response: only digit 0 lights, seg_o = 0x07. With digits 0,0,0,0, digit 0 shows 0x3F. With blank_lz_i = 0, all four digits light.
- Invalid BCD and dp:
  - Stimulus: digit 1 = 4'hB, dp_i = 0010.
  - Response: in slot 1, seg_o = 0x40 and dp_o = 1; dp_o = 0 in all other slots.
- Tear-free update:
  - Stimulus: update_i mid-frame with new values.
  - Response: the remaining slots of the current frame show the old values; the new values appear from slot 0 of the next frame.
  - Stimulus: update_i exactly in the boundary cycle.
  - Response: new values appear in the immediately following frame.
- Brightness and polarity:
  - Stimulus: brightness 0.
  - Response: dig_sel_o never active.
  - Stimulus: brightness 8.
  - Response: exactly 8 of every 16 non-guard cycles lit.
  - Stimulus: COMMON_ANODE = 1 build, same digits.
  - Response: all outputs are bitwise complements of the COMMON_ANODE = 0 run.
